fetcher: RTL and testbench
==========================

FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, instruction-queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 rdy_in  input  1  global enable; low SHALL freeze all state.
REQ-006 ic_req  output  1  instruction-cache read request, registered.
REQ-007 ic_addr  output  32  request address, registered, word-aligned.
REQ-008 ic_valid  input  1  one-cycle pulse: ic_inst holds the data for the outstanding request.
REQ-009 ic_inst  input  32  returned instruction word.
REQ-010 ID_stall  input  1  decode stage cannot accept an instruction this cycle.
REQ-011 clr_flag  input  1  misprediction or redirect; flush and restart.
REQ-012 clr_pc  input  32  restart address, valid while clr_flag is high.
REQ-013 inst_flag  output  1  inst and inst_pc are valid and consumed this cycle.
REQ-014 inst  output  32  instruction word handed to decode.
REQ-015 inst_pc  output  32  address of inst.

Function
REQ-016 fetch_pc register SHALL hold the next address to request; it SHALL advance by 4 per accepted response and wrap modulo 2^32.
REQ-017 FSM states:
- IDLE: no outstanding request.
- WAIT: request outstanding, response will be kept.
- DROP: request outstanding, response will be discarded.
REQ-018 IDLE->WAIT when (queue count + 0) < QUEUE_DEPTH and clr_flag low.
- ic_req<=1 and ic_addr<=fetch_pc on that edge.
REQ-019 In WAIT and DROP, ic_req and ic_addr SHALL hold stable until the edge on which ic_valid=1 is sampled.
- At most one request SHALL ever be outstanding.
REQ-020 WAIT with ic_valid=1 and clr_flag=0:
- push {ic_addr, ic_inst} into the queue;
- fetch_pc<=fetch_pc+4;
- ic_req<=0; state->IDLE.
REQ-021 DROP with ic_valid=1: discard the data, ic_req<=0, state->IDLE.
REQ-022 A request SHALL only be issued when a queue slot is free, so a push SHALL never overflow, even with a simultaneous pop.
REQ-023 inst_flag = queue non-empty AND NOT ID_stall AND rdy_in AND NOT clr_flag (combinational).
- inst and inst_pc SHALL show the queue head; they SHALL be 0 when the queue is empty.
- The head is popped on every edge where inst_flag=1.
REQ-024 Latency: response pushed at edge t into an empty queue SHALL give inst_flag=1 in cycle t+1 (given no stall).
- Push and pop on the same edge SHALL both take effect.
REQ-025 clr_flag=1 at an edge SHALL:
- empty the queue;
- set fetch_pc<=clr_pc;
- WAIT->DROP, DROP stays DROP, IDLE stays IDLE (no new request that edge).
REQ-026 clr_flag and ic_valid on the same edge: the response SHALL be discarded and state->IDLE.
- clr_flag takes priority over push, pop and request issue.
REQ-027 Queue read/write pointers SHALL wrap modulo QUEUE_DEPTH.
- Full and empty SHALL be distinguished by an explicit count.
REQ-028 rdy_in=0 SHALL hold every register, including ic_req and ic_addr; ic_valid is not sampled that cycle.

Reset
REQ-029 On rst_in=1 at an edge: fetch_pc<=RESET_PC, queue empty, state IDLE, ic_req<=0, ic_addr<=0; hence inst_flag=0, inst=0, inst_pc=0.
REQ-030 rst_in SHALL override rdy_in and clr_flag.
- An outstanding cache response arriving after reset SHALL be ignored (state IDLE).

Structure
REQ-031 True/False, the FSM state encodings and the default RESET_PC SHALL live in the shared defines header used by the decode stage.
REQ-032 The queue SHALL be a sub-module inst_queue.
- Ports: push, push_data[63:0], pop, clr, empty, full, count, head[63:0].
- The FSM and PC logic stay in fetcher.

Verification
REQ-033 Reset, then cache answering every request 2 cycles later with inst=addr^32'hA5A5A5A5, ID_stall=0 -> inst_pc sequence 0,4,8,12…; each inst matches.
REQ-034 ID_stall=1 for 20 cycles -> exactly 4 entries queued, ic_req stays 0 afterwards; release -> 4 pops in 4 consecutive cycles with in-order pc 0..12.
REQ-035 clr_flag with clr_pc=32'h100 while WAIT on addr 8 -> ic_req/ic_addr stay at 8 until ic_valid; response is dropped; next request is 32'h100 and first inst_pc is 32'h100.
REQ-036 clr_flag and ic_valid on the same edge -> no push, queue empty, next ic_addr=clr_pc.
REQ-037 RESET_PC=32'hFFFFFFF8 -> inst_pc sequence FFFFFFF8, FFFFFFFC, 0, 4.
REQ-038 rdy_in=0 for 5 cycles mid-WAIT with ic_valid pulsed -> no state change, no inst_flag; normal operation resumes once rdy_in=1.

Source files
------------

// File: rtl/fetcher_pkg.sv
// ---------------------------------------------------------------------------
// fetcher_pkg
// Definitions shared by the fetch and decode stages: boolean constants, the
// fetch FSM state encoding, the default reset PC and the layout of one
// instruction-queue entry.
// No ports (package).
// ---------------------------------------------------------------------------
package fetcher_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // ST_IDLE : no cache request outstanding
    // ST_WAIT : request outstanding, its response will be queued
    // ST_DROP : request outstanding, its response will be thrown away
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    // One queued instruction: the address it was fetched from and its word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } queue_entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetcher_inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
// Small circular FIFO holding fetched {pc, inst} pairs between the cache and
// the decode stage.  Full/empty come from an explicit occupancy count so the
// pointers can simply wrap modulo DEPTH.
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, empties the queue
//   en         global enable; low freezes pointers, count and storage
//   push       write push_data at the tail
//   push_data  64-bit entry {pc, inst}
//   pop        drop the head entry
//   clr        flush: empty the queue (wins over push and pop)
//   empty      no entries held
//   full       DEPTH entries held
//   count      number of entries held (0..DEPTH)
//   head       oldest entry, forced to zero while empty
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module inst_queue
    import fetcher_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          push,
    input  logic [63:0]   push_data,
    input  logic          pop,
    input  logic          clr,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic [63:0]   head
);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign head   = empty ? 64'h0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointer width makes the wrap free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (clr) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst && en && !clr && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetcher.sv
// ---------------------------------------------------------------------------
// fetcher
// Instruction fetch stage.  Issues one word-aligned read at a time to the
// instruction cache, queues returned words with their addresses, and hands
// the queue head to decode.  A redirect (clr_flag) flushes the queue, moves
// the fetch PC and turns any in-flight request into one whose data is dropped.
// Ports:
//   clk_in     clock
//   rst_in     synchronous active-high reset (overrides rdy_in and clr_flag)
//   rdy_in     global enable; low freezes every register
//   ic_req     cache read request (registered)
//   ic_addr    cache read address (registered, word aligned)
//   ic_valid   one-cycle pulse, ic_inst carries the outstanding response
//   ic_inst    returned instruction word
//   ID_stall   decode cannot take an instruction this cycle
//   clr_flag   redirect / misprediction flush
//   clr_pc     restart address while clr_flag is high
//   inst_flag  inst/inst_pc valid and consumed this cycle
//   inst       instruction word to decode (0 when queue empty)
//   inst_pc    address of inst (0 when queue empty)
// ---------------------------------------------------------------------------
module fetcher
    import fetcher_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_inst,
    input  logic        ID_stall,
    input  logic        clr_flag,
    input  logic [31:0] clr_pc,
    output logic        inst_flag,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e  state;
    fetch_state_e  state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic          ic_req_nxt;
    logic [31:0]   ic_addr_nxt;
    logic          push_req;

    logic          q_push;
    logic          q_empty;
    logic          q_full;
    logic [CW-1:0] q_count;
    queue_entry_t  q_head;
    queue_entry_t  q_push_data;

    assign q_push_data = '{pc: ic_addr, inst: ic_inst};

    // Defensive: issue already requires a free slot, so this never blocks.
    assign q_push = push_req && (!q_full || inst_flag);

    assign inst_flag = !q_empty && !ID_stall && rdy_in && !clr_flag;
    assign inst      = q_head.inst;
    assign inst_pc   = q_head.pc;

    inst_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_inst_queue (
        .clk       (clk_in),
        .rst       (rst_in),
        .en        (rdy_in),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (inst_flag),
        .clr       (clr_flag),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count),
        .head      (q_head)
    );

    // Next-state logic.  A request is only launched while a queue slot is
    // free (count taken before this edge's pop), so responses never overflow.
    // A redirect always wins: it blocks issue, suppresses the push, and its
    // restart address overrides the normal +4 advance.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        ic_req_nxt   = ic_req;
        ic_addr_nxt  = ic_addr;
        push_req     = FALSE;

        case (state)
            ST_IDLE: begin
                if (!clr_flag && (q_count < CW'(QUEUE_DEPTH))) begin
                    state_nxt   = ST_WAIT;
                    ic_req_nxt  = TRUE;
                    ic_addr_nxt = fetch_pc;
                end
            end
            ST_WAIT: begin
                if (ic_valid) begin
                    state_nxt  = ST_IDLE;
                    ic_req_nxt = FALSE;
                    if (!clr_flag) begin
                        push_req     = TRUE;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                    end
                end else if (clr_flag) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (ic_valid) begin
                    state_nxt  = ST_IDLE;
                    ic_req_nxt = FALSE;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                ic_req_nxt = FALSE;
            end
        endcase

        if (clr_flag) begin
            fetch_pc_nxt = align_word(clr_pc);
        end
    end

    // State register: reset first, then everything frozen while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            fetch_pc <= align_word(RESET_PC);
            ic_req   <= FALSE;
            ic_addr  <= 32'h0;
        end else if (rdy_in) begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            ic_req   <= ic_req_nxt;
            ic_addr  <= ic_addr_nxt;
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// ---------------------------------------------------------------------------
// tb_fetcher
// Directed bench for the fetch stage.  A behavioural instruction cache answers
// each request a fixed number of cycles later with addr ^ 32'hA5A5A5A5; every
// response the fetcher should keep is pushed to a scoreboard and popped when
// decode consumes an instruction.  A second instance with RESET_PC near the
// top of the address space checks PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetcher;

    localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        ID_stall;
    logic        clr_flag;
    logic [31:0] clr_pc;

    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_inst;
    logic        inst_flag;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        ic_req_b;
    logic [31:0] ic_addr_b;
    logic        ic_valid_b;
    logic [31:0] ic_inst_b;
    logic        inst_flag_b;
    logic [31:0] inst_b;
    logic [31:0] inst_pc_b;

    int          vectors = 0;
    int          miscompares = 0;

    exp_t        sb[$];
    logic [31:0] model_pc = 32'h0;
    logic [31:0] resp_addr = 32'h0;
    bit          busy = 1'b0;
    bit          drop = 1'b0;
    int          age = 0;
    int          seen_flags = 0;

    bit          busy_b = 1'b0;
    int          age_b = 0;
    logic [31:0] addr_b = 32'h0;
    int          n_wrap = 0;
    logic [31:0] wrap_seq [4];

    always #5 clk_in = ~clk_in;

    fetcher #(
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_valid  (ic_valid),
        .ic_inst   (ic_inst),
        .ID_stall  (ID_stall),
        .clr_flag  (clr_flag),
        .clr_pc    (clr_pc),
        .inst_flag (inst_flag),
        .inst      (inst),
        .inst_pc   (inst_pc)
    );

    fetcher #(
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .ic_req    (ic_req_b),
        .ic_addr   (ic_addr_b),
        .ic_valid  (ic_valid_b),
        .ic_inst   (ic_inst_b),
        .ID_stall  (ID_stall),
        .clr_flag  (clr_flag),
        .clr_pc    (clr_pc),
        .inst_flag (inst_flag_b),
        .inst      (inst_b),
        .inst_pc   (inst_pc_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock: check outputs against the scoreboard, take the edge, then
    // advance both cache models using the values sampled at that edge.
    task automatic stepCycle();
        exp_t        e;
        logic        exp_flag;
        logic        rst_s, rdy_s, valid_s, valid_b_s, clr_s;
        logic [31:0] clrpc_s;

        #1;
        if (!rst_in) begin
            exp_flag = (sb.size() != 0) && !ID_stall && rdy_in && !clr_flag;
            checkOutput("inst_flag", 32'(inst_flag), 32'(exp_flag));
            if (inst_flag === 1'b1) seen_flags++;
            if (exp_flag) begin
                e = sb.pop_front();
                checkOutput("inst_pc", inst_pc, e.pc);
                checkOutput("inst", inst, e.inst);
            end else if (sb.size() == 0) begin
                checkOutput("inst_pc_empty", inst_pc, 32'h0);
                checkOutput("inst_empty", inst, 32'h0);
            end
            if (inst_flag_b === 1'b1 && n_wrap < 4) begin
                checkOutput("wrap_pc", inst_pc_b, wrap_seq[n_wrap]);
                checkOutput("wrap_inst", inst_b, wrap_seq[n_wrap] ^ MAGIC);
                n_wrap++;
            end
        end
        rst_s     = rst_in;
        rdy_s     = rdy_in;
        valid_s   = ic_valid;
        valid_b_s = ic_valid_b;
        clr_s     = clr_flag;
        clrpc_s   = clr_pc;

        @(posedge clk_in);
        #1;

        if (rst_s) begin
            sb.delete();
            model_pc = 32'h0;
            busy     = 1'b0;
            drop     = 1'b0;
            ic_valid = 1'b0;
        end else begin
            if (rdy_s) begin
                if (busy && valid_s) begin
                    if (!drop && !clr_s) begin
                        sb.push_back('{resp_addr, resp_addr ^ MAGIC});
                        model_pc = model_pc + 32'd4;
                    end
                    busy     = 1'b0;
                    ic_valid = 1'b0;
                end
                if (clr_s) begin
                    sb.delete();
                    model_pc = {clrpc_s[31:2], 2'b00};
                    if (busy) drop = 1'b1;
                end
            end
            if (busy) begin
                checkOutput("ic_req_hold", 32'(ic_req), 32'd1);
                checkOutput("ic_addr_hold", ic_addr, resp_addr);
                if (rdy_s) begin
                    age++;
                    if (age >= 2 && !ic_valid) begin
                        ic_valid = 1'b1;
                        ic_inst  = resp_addr ^ MAGIC;
                    end
                end
            end else if (ic_req === 1'b1) begin
                checkOutput("ic_addr_issue", ic_addr, model_pc);
                busy      = 1'b1;
                age       = 0;
                drop      = 1'b0;
                resp_addr = model_pc;
            end
        end

        if (rst_s) begin
            busy_b     = 1'b0;
            ic_valid_b = 1'b0;
        end else if (rdy_s) begin
            if (busy_b && valid_b_s) begin
                busy_b     = 1'b0;
                ic_valid_b = 1'b0;
            end
            if (busy_b) begin
                age_b++;
                if (age_b >= 1 && !ic_valid_b) begin
                    ic_valid_b = 1'b1;
                    ic_inst_b  = addr_b ^ MAGIC;
                end
            end else if (ic_req_b === 1'b1) begin
                busy_b = 1'b1;
                age_b  = 0;
                addr_b = ic_addr_b;
            end
        end
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            stepCycle();
        end
    endtask

    initial begin
        bit found;
        int flags_before;

        wrap_seq[0] = 32'hFFFF_FFF8;
        wrap_seq[1] = 32'hFFFF_FFFC;
        wrap_seq[2] = 32'h0000_0000;
        wrap_seq[3] = 32'h0000_0004;

        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        ID_stall   = 1'b0;
        clr_flag   = 1'b0;
        clr_pc     = 32'h0;
        ic_valid   = 1'b0;
        ic_inst    = 32'h0;
        ic_valid_b = 1'b0;
        ic_inst_b  = 32'h0;

        // Reset state
        applyStimulus(2);
        rst_in = 1'b0;
        #1;
        checkOutput("rst_ic_req", 32'(ic_req), 32'd0);
        checkOutput("rst_ic_addr", ic_addr, 32'h0);
        checkOutput("rst_inst_flag", 32'(inst_flag), 32'd0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_inst_pc", inst_pc, 32'h0);

        // Decode stalled: queue fills to depth and fetching stops
        ID_stall = 1'b1;
        applyStimulus(20);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_ic_req", 32'(ic_req), 32'd0);
            applyStimulus(1);
        end
        checkOutput("stall_head_pc", inst_pc, 32'h0);

        // Release: four back-to-back pops in order
        ID_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("release_flag", 32'(inst_flag), 32'd1);
            checkOutput("release_pc", inst_pc, 32'(i * 4));
            applyStimulus(1);
        end

        // Free-running stream
        applyStimulus(30);

        // Redirect while waiting on address 8: response dropped
        rst_in = 1'b1;
        applyStimulus(1);
        rst_in = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (ic_req === 1'b1 && ic_addr === 32'h8 && busy && age == 0) found = 1'b1;
            else applyStimulus(1);
        end
        checkOutput("wait_addr8_seen", 32'(found), 32'd1);
        clr_flag = 1'b1;
        clr_pc   = 32'h100;
        applyStimulus(1);
        clr_flag = 1'b0;
        clr_pc   = 32'h0;
        checkOutput("drop_req_hold", 32'(ic_req), 32'd1);
        checkOutput("drop_addr_hold", ic_addr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (inst_flag === 1'b1) begin
                found = 1'b1;
                checkOutput("redirect_first_pc", inst_pc, 32'h100);
            end
            applyStimulus(1);
        end
        checkOutput("redirect_seen", 32'(found), 32'd1);

        // Redirect on the same edge as a response
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (ic_valid === 1'b1 && !drop) found = 1'b1;
            else applyStimulus(1);
        end
        checkOutput("valid_seen", 32'(found), 32'd1);
        clr_flag = 1'b1;
        clr_pc   = 32'h200;
        applyStimulus(1);
        clr_flag = 1'b0;
        clr_pc   = 32'h0;
        #1;
        checkOutput("clrv_ic_req", 32'(ic_req), 32'd0);
        checkOutput("clrv_inst_flag", 32'(inst_flag), 32'd0);
        checkOutput("clrv_inst_pc", inst_pc, 32'h0);
        applyStimulus(1);
        checkOutput("clrv_next_req", 32'(ic_req), 32'd1);
        checkOutput("clrv_next_addr", ic_addr, 32'h200);

        // Global enable low mid-request with a stray response pulse
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ic_valid = (i == 2);
            ic_inst  = 32'hDEAD_BEEF;
            applyStimulus(1);
            checkOutput("frz_ic_req", 32'(ic_req), 32'd1);
            checkOutput("frz_ic_addr", ic_addr, 32'h200);
            checkOutput("frz_inst_flag", 32'(inst_flag), 32'd0);
        end
        ic_valid = 1'b0;
        rdy_in   = 1'b1;
        flags_before = seen_flags;
        applyStimulus(20);
        checkOutput("resume_pops", 32'(seen_flags > flags_before), 32'd1);

        checkOutput("wrap_count", 32'(n_wrap), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
